// File: rtl/tb_periph_pkg.sv
// Shared definitions for the bench-control peripheral.
// Holds the register offsets inside the 4 KiB window, the default pass/fail
// codes, the STATUS field positions and the decoded register select type,
// plus two small helpers used by the top-level decode and timer logic.
package tb_periph_pkg;

  // Register offsets, relative to BASE_ADDR
  localparam logic [11:0] OFF_PRINT    = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_TEST     = 12'h008;
  localparam logic [11:0] OFF_EXIT     = 12'h00C;
  localparam logic [11:0] OFF_MTIME_LO = 12'h010;
  localparam logic [11:0] OFF_MTIME_HI = 12'h014;
  localparam logic [11:0] OFF_CMP_LO   = 12'h018;
  localparam logic [11:0] OFF_CMP_HI   = 12'h01C;

  // Firmware handshake codes written to TEST_RESULT
  localparam logic [31:0] PASS_CODE_DEFAULT = 32'd123456789;
  localparam logic [31:0] FAIL_CODE_DEFAULT = 32'd1;

  // STATUS layout: {16'b0, level[7:0], 7'b0, full}
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_LEVEL_LSB = 8;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_PRINT,
    SEL_STATUS,
    SEL_TEST,
    SEL_EXIT,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI
  } reg_sel_e;

  // Maps a window offset to a register select; anything unlisted is SEL_NONE
  function automatic reg_sel_e decode_offset(input logic [11:0] off);
    reg_sel_e sel;
    case (off)
      OFF_PRINT:    sel = SEL_PRINT;
      OFF_STATUS:   sel = SEL_STATUS;
      OFF_TEST:     sel = SEL_TEST;
      OFF_EXIT:     sel = SEL_EXIT;
      OFF_MTIME_LO: sel = SEL_MTIME_LO;
      OFF_MTIME_HI: sel = SEL_MTIME_HI;
      OFF_CMP_LO:   sel = SEL_CMP_LO;
      OFF_CMP_HI:   sel = SEL_CMP_HI;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Byte-enable merge of new data over an old 32-bit value
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tb_stdout_fifo.sv
// Synchronous 8-bit FIFO buffering characters for the stdout consumer.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (flushes contents)
//   push_i, data_i    write a character (ignored when full)
//   pop_i             remove the head character (ignored when empty)
//   data_o            head character, 0 while empty
//   full_o, empty_o   registered occupancy flags
//   level_o           number of stored characters, 0..DEPTH
module tb_stdout_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; data_o is masked while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tb_ctrl_periph.sv
// Memory-mapped bench-control responder on an OBI-style data bus.
// Firmware writes here to report pass/fail, request exit and print characters;
// it also provides a 64-bit machine timer with a compare interrupt.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   data_req_i/gnt_o/addr_i/we_i/be_i/wdata_i   bus request channel
//   data_rvalid_o/rdata_o/err_o     bus response, one cycle after grant
//   stdout_valid_o/data_o/ready_i   character stream to the stdout consumer
//   tests_passed_o/tests_failed_o   one-cycle result pulses
//   exit_valid_o/exit_value_o       exit pulse and held exit code
//   timer_irq_o                     registered mtime >= mtimecmp
module tb_ctrl_periph
  import tb_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [31:0] PASS_CODE      = PASS_CODE_DEFAULT,
  parameter logic [31:0] FAIL_CODE      = FAIL_CODE_DEFAULT,
  parameter int unsigned TIMER_PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timer_irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e          sel;
  logic              in_window, aligned, gnt, wr_en, rd_en;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LVL_W-1:0]  fifo_level;
  logic [31:0]       status_word;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        passed_q, passed_d, failed_q, failed_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic [31:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;
  logic        tick;

  // Address decode: outside the window or misaligned falls to SEL_NONE
  assign in_window = (data_addr_i[31:12] == BASE_ADDR[31:12]);
  assign aligned   = (data_addr_i[1:0] == 2'b00);
  assign sel       = (in_window && aligned) ? decode_offset(data_addr_i[11:0]) : SEL_NONE;

  // Only a PRINT write against a full FIFO is stalled; the registered level
  // is used, so a pop in the same cycle does not open a slot
  assign gnt        = data_req_i & ~((sel == SEL_PRINT) & data_we_i & fifo_full);
  assign data_gnt_o = gnt;
  assign wr_en      = gnt & data_we_i;
  assign rd_en      = gnt & ~data_we_i;

  assign fifo_push      = wr_en & (sel == SEL_PRINT) & data_be_i[0];
  assign fifo_pop       = ~fifo_empty & stdout_ready_i;
  assign stdout_valid_o = ~fifo_empty;

  tb_stdout_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (data_wdata_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (stdout_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    status_word = '0;
    status_word[STATUS_LEVEL_LSB +: 8] = 8'(fifo_level);
    status_word[STATUS_FULL_BIT]       = fifo_full;
  end

  // Response and pulse next-state; error responses leave rdata at zero
  always_comb begin
    rvalid_d     = gnt;
    err_d        = gnt & (sel == SEL_NONE);
    rdata_d      = '0;
    passed_d     = wr_en & (sel == SEL_TEST) & (data_wdata_i == PASS_CODE);
    failed_d     = wr_en & (sel == SEL_TEST) & (data_wdata_i == FAIL_CODE);
    exit_valid_d = wr_en & (sel == SEL_EXIT);
    exit_value_d = exit_valid_d ? data_wdata_i : exit_value_q;
    if (rd_en) begin
      case (sel)
        SEL_STATUS:   rdata_d = status_word;
        SEL_MTIME_LO: rdata_d = mtime_q[31:0];
        SEL_MTIME_HI: rdata_d = mtime_q[63:32];
        SEL_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        SEL_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        default:      rdata_d = '0;
      endcase
    end
  end

  // Timer: a bus write to either mtime half replaces that cycle's increment
  // and leaves the other half as it was
  always_comb begin
    tick       = (presc_q == 32'(TIMER_PRESCALE - 1));
    presc_d    = tick ? '0 : presc_q + 32'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_en) begin
      case (sel)
        SEL_MTIME_LO: mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], data_wdata_i, data_be_i)};
        SEL_MTIME_HI: mtime_d = {apply_be(mtime_q[63:32], data_wdata_i, data_be_i), mtime_q[31:0]};
        SEL_CMP_LO:   mtimecmp_d[31:0]  = apply_be(mtimecmp_q[31:0], data_wdata_i, data_be_i);
        SEL_CMP_HI:   mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], data_wdata_i, data_be_i);
        default:      ;
      endcase
    end
    irq_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      presc_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      irq_q        <= 1'b0;
    end else begin
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      irq_q        <= irq_d;
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign data_err_o     = err_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign timer_irq_o    = irq_q;

endmodule
